// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller
//   Main control unit for the multicycle MIPS core. It is a Moore FSM that
//   steps the shared datapath through fetch, decode, execute, memory and
//   writeback, plus a combinational ALU decoder.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   op, funct          instr[31:26] / instr[5:0] from the instruction register
//   zero               ALU zero flag, only used in BEQEX
//   pcen               PC load enable (pcwrite | branch & zero)
//   memwrite, irwrite, regwrite   write strobes
//   alusrca, alusrcb, iord, memtoreg, regdst, pcsrc   datapath mux selects
//   alucontrol         ALU operation
//   state              current FSM state, for debug
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     state_q, state_d, dec_state;
  logic       pcwrite, branch;
  logic       irwrite_raw, regwrite_raw, memwrite_raw;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Next state. Unused encodings fall into the default and recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // While reset is held the selects show the FETCH decode, so the datapath
  // sees a clean fetch setup the moment reset drops.
  assign dec_state = reset ? FETCH : state_q;

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    case (dec_state)
      FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      ADDIWB:  regwrite_raw = 1'b1;
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are suppressed during reset so an aborted instruction
  // leaves no architectural side effect.
  assign pcen     = ~reset & (pcwrite | (branch & zero));
  assign irwrite  = ~reset & irwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign memwrite = ~reset & memwrite_raw;

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: walks each instruction class
// through its state sequence and checks selects and strobes per state.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  int rw_cnt = 0;
  int mw_cnt = 0;

  mips_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (regwrite) rw_cnt <= rw_cnt + 1;
    if (memwrite) mw_cnt <= mw_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic st(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, state}, {28'd0, exp});
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      st("rst_state", 4'd0);
      chk("rst_strobes", {pcen, irwrite, regwrite, memwrite}, 4'b0000);
      chk("rst_alusrcb", alusrcb, 2'b01);
    end
    reset = 1'b0; #1;
    chk("fetch_irwrite", irwrite, 1'b1);
    chk("fetch_pcen", pcen, 1'b1);
    chk("fetch_alusrcb", alusrcb, 2'b01);
    chk("fetch_aluc", alucontrol, 3'b010);

    // lw: 0,1,2,3,4,0
    rw_cnt = 0;
    st("lw_s0", 4'd0);
    tick(); st("lw_s1", 4'd1); chk("dec_alusrcb", alusrcb, 2'b11);
    chk("dec_strobes", {pcen, irwrite, regwrite, memwrite}, 4'b0000);
    tick(); st("lw_s2", 4'd2); chk("madr_sel", {alusrca, alusrcb}, 3'b110);
    tick(); st("lw_s3", 4'd3); chk("memrd_iord", iord, 1'b1);
    tick(); st("lw_s4", 4'd4);
    chk("memwb_sel", {memtoreg, regwrite, regdst}, 3'b110);
    tick(); st("lw_end", 4'd0);
    chk("lw_rw_pulses", rw_cnt, 1);

    // sw: 0,1,2,5,0
    op = 6'b101011; mw_cnt = 0;
    tick(); st("sw_s1", 4'd1);
    tick(); st("sw_s2", 4'd2); chk("sw_madr_mw", memwrite, 1'b0);
    tick(); st("sw_s5", 4'd5); chk("memwr_sel", {memwrite, iord}, 2'b11);
    tick(); st("sw_end", 4'd0);
    chk("sw_mw_pulses", mw_cnt, 1);

    // R-type slt: 0,1,6,7,0
    op = 6'b000000; funct = 6'b101010;
    tick(); st("r_s1", 4'd1);
    tick(); st("r_s6", 4'd6); chk("r_slt", alucontrol, 3'b111);
    chk("r_alusrc", {alusrca, alusrcb}, 3'b100);
    funct = 6'b100000; #1; chk("r_add", alucontrol, 3'b010);
    funct = 6'b100010; #1; chk("r_sub", alucontrol, 3'b110);
    funct = 6'b100100; #1; chk("r_and", alucontrol, 3'b000);
    funct = 6'b100101; #1; chk("r_or", alucontrol, 3'b001);
    funct = 6'b111111; #1; chk("r_dflt", alucontrol, 3'b010);
    funct = 6'b101010;
    tick(); st("r_s7", 4'd7); chk("rwb_sel", {regdst, regwrite}, 2'b11);
    tick(); st("r_end", 4'd0);

    // beq taken
    op = 6'b000100; zero = 1'b1;
    tick(); st("beq_s1", 4'd1);
    chk("beq_dec_pcen", pcen, 1'b0);
    tick(); st("beq_s8", 4'd8);
    chk("beqt_pcen", pcen, 1'b1);
    chk("beqt_pcsrc", pcsrc, 2'b01);
    chk("beqt_aluc", alucontrol, 3'b110);
    tick(); st("beqt_end", 4'd0);
    // beq not taken
    zero = 1'b0;
    tick(); st("beqn_s1", 4'd1);
    tick(); st("beqn_s8", 4'd8);
    chk("beqn_pcen", pcen, 1'b0);
    tick(); st("beqn_end", 4'd0);

    // j: 0,1,11,0
    op = 6'b000010;
    tick(); st("j_s1", 4'd1);
    tick(); st("j_s11", 4'd11);
    chk("j_sel", {pcsrc, pcen}, 3'b101);
    tick(); st("j_end", 4'd0);

    // addi: 0,1,9,10,0
    op = 6'b001000;
    tick(); st("addi_s1", 4'd1);
    tick(); st("addi_s9", 4'd9); chk("addiex_sel", {alusrca, alusrcb}, 3'b110);
    tick(); st("addi_s10", 4'd10); chk("addiwb_sel", {regwrite, regdst}, 2'b10);
    tick(); st("addi_end", 4'd0);

    // unsupported op: 0,1,0
    op = 6'b111111;
    tick(); st("nop_s1", 4'd1);
    chk("nop_strobes", {pcen, irwrite, regwrite, memwrite}, 4'b0000);
    tick(); st("nop_end", 4'd0);

    // reset in MEMRD aborts lw
    op = 6'b100011; rw_cnt = 0;
    tick(); st("ab_s1", 4'd1);
    tick(); st("ab_s2", 4'd2);
    tick(); st("ab_s3", 4'd3);
    reset = 1'b1; #1;
    chk("ab_strobes", {pcen, irwrite, regwrite, memwrite}, 4'b0000);
    tick(); st("ab_rst", 4'd0);
    reset = 1'b0; #1;
    chk("ab_fetch_ir", irwrite, 1'b1);
    tick(); st("ab_s1b", 4'd1);
    chk("ab_rw_none", rw_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Main control unit for the multicycle MIPS core. Sequences the shared datapath (single unified memory, one ALU, PC and instruction register) through fetch, decode, execute, memory and writeback steps for each instruction. A Moore FSM plus a combinational ALU decoder. Sits inside `top`'s processor beside the datapath and drives every mux select and write enable the datapath exposes.

## Interface
- No parameters; opcode and funct encodings are fixed MIPS-I values.
- clk  in  1  system clock, rising-edge active
- reset  in  1  synchronous, active-high; returns FSM to FETCH
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag (registered ALU result compare, valid in BEQEX)
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = signext imm, 11 = signext imm << 2
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = memory data
- regdst  out  1  dest register: 0 = rt, 1 = rd
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation
- state  out  4  current state encoding, debug only

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Encodings 12–15 unused; if reached, go to FETCH.
- Transitions: FETCH→DECODE. DECODE by op: 100011 lw / 101011 sw → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX; any other op → FETCH (treated as nop). MEMADR→MEMRD if lw, MEMWR if sw. MEMRD→MEMWB. RTYPEEX→RTYPEWB. ADDIEX→ADDIWB. MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
- Outputs per state. Any signal not listed is 0, including pcsrc = 00 and alusrcb = 00:
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR / ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWR: iord=1, memwrite=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - JEX: pcsrc=10, pcwrite=1.
- ALU decoder (combinational), by aluop:
  - aluop 00 → 010 (add); aluop 01 → 110 (sub).
  - aluop 10, by funct: 100000 → 010, 100010 → 110, 100100 → 000 (and), 100101 → 001 (or), 101010 → 111 (slt). Any other funct → 010.
  - aluop 11 is unused and gives 010.

## Timing
- State register updates on the rising clk edge. All outputs are combinational from state, plus op/funct/zero where noted. No output registers.
- Reset: while reset=1 at a rising edge, state ← FETCH. While reset is high, pcen, irwrite, regwrite and memwrite are forced to 0 regardless of state; the other outputs show the FETCH values. The first fetch happens in the first cycle with reset=0.
- Reset asserted mid-instruction aborts the instruction; no write enable is asserted in that cycle.
- Cycles per instruction, counted from FETCH through the last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported op 2.
- pcen in BEQEX follows zero combinationally within the same cycle. zero is ignored in all other states.
- op and funct are sampled only in DECODE and MEMADR (state transitions) and in RTYPEEX (alucontrol). The datapath holds them stable because irwrite=0 outside FETCH.

## Test plan
- Reset: hold reset=1 for 3 cycles with op=100011 → state=0, and pcen=irwrite=regwrite=memwrite=0 throughout. Release reset → next cycle irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw, op=100011 → state sequence 0,1,2,3,4,0. MEMRD gives iord=1. MEMWB gives memtoreg=1, regwrite=1, regdst=0. Exactly one regwrite pulse.
- sw then R-type:
  - sw, op=101011 → states 0,1,2,5,0. memwrite=1 only in state 5, with iord=1.
  - R-type, op=000000, funct=101010 → states 0,1,6,7,0. alucontrol=111 in state 6; regdst=1, regwrite=1 in state 7.
- beq, op=000100:
  - zero=1 → pcen=1, pcsrc=01, alucontrol=110 in state 8.
  - zero=0 → pcen=0 in state 8.
  - Both cases return to state 0 next cycle.
- j and addi:
  - j, op=000010 → states 0,1,11,0, with pcsrc=10 and pcen=1 in state 11.
  - addi, op=001000 → states 0,1,9,10,0, with regwrite=1 and regdst=0 in state 10.
- Unsupported op=111111 → states 0,1,0; no write enable asserted in DECODE. Reset asserted while in state 3 → state=0 next edge, regwrite never asserted.
